// File: rtl/sequence_player_if.sv
// Sequence player bus: run/length controls, pattern-memory read port and LED-side outputs.
// master = the player, slave = the memory / control side.
interface sequence_player_if #(
  parameter int unsigned MEM_WIDTH  = 2,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  run;
  logic [ADDR_WIDTH:0]   seq_len;
  logic [MEM_WIDTH-1:0]  r_data;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [MEM_WIDTH-1:0]  led;
  logic                  wrap;
  logic                  playing;

  modport master (
    input  run, seq_len, r_data,
    output r_en, r_addr, led, wrap, playing
  );

  modport slave (
    output run, seq_len, r_data,
    input  r_en, r_addr, led, wrap, playing
  );
endinterface

// File: rtl/sequence_player.sv
// LED sequence playback engine: fetches pattern words step by step and loops over seq_len.
// Optional bounce (0..len-1..0) playback is enabled by defining SEQUENCE_PLAYER_PINGPONG_EN.
module sequence_player #(
  parameter int unsigned MEM_WIDTH  = 2,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_STEPS  = 8,
  parameter int unsigned HOLD_TICKS = 1
) (
  input  logic              div_clk,
  input  logic              rst,
  sequence_player_if.master bus
);

  localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
  localparam int unsigned HOLD_W = 4;
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(NUM_STEPS);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHOW
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  r_en_q, r_en_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [MEM_WIDTH-1:0]  led_q, led_d;
  logic                  wrap_q, wrap_d;
  logic                  playing_q, playing_d;
  logic                  restart_c;
  logic                  advance_c;
  logic [LEN_W-1:0]      len_clamp_c;
  logic [ADDR_WIDTH-1:0] last_ptr_c;
`ifdef SEQUENCE_PLAYER_PINGPONG_EN
  logic                  dir_q, dir_d;  // 0 = up, 1 = down
`endif

  assign len_clamp_c = (bus.seq_len > MAX_LEN) ? MAX_LEN : bus.seq_len;
  assign last_ptr_c  = ADDR_WIDTH'(len_q - LEN_W'(1));

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    len_d     = len_q;
    r_en_d    = 1'b0;
    r_addr_d  = r_addr_q;
    led_d     = led_q;
    wrap_d    = 1'b0;
    playing_d = playing_q;
    restart_c = 1'b0;
    advance_c = 1'b0;
`ifdef SEQUENCE_PLAYER_PINGPONG_EN
    dir_d     = dir_q;
`endif

    case (state_q)
      S_IDLE: begin
        led_d     = '0;
        playing_d = 1'b0;
        if (bus.run && (bus.seq_len != '0)) begin
          len_d     = len_clamp_c;
          ptr_d     = '0;
          advance_c = 1'b1;
`ifdef SEQUENCE_PLAYER_PINGPONG_EN
          dir_d     = 1'b0;
`endif
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        led_d   = bus.r_data;
        hold_d  = HOLD_INIT;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (!bus.run) begin
          state_d   = S_IDLE;
          led_d     = '0;
          playing_d = 1'b0;
        end else begin
`ifdef SEQUENCE_PLAYER_PINGPONG_EN
          if (len_q == LEN_W'(1)) begin
            ptr_d     = '0;
            restart_c = 1'b1;
          end else if (!dir_q) begin
            if (ptr_q == last_ptr_c) begin
              dir_d = 1'b1;
              ptr_d = ptr_q - ADDR_WIDTH'(1);
            end else begin
              ptr_d = ptr_q + ADDR_WIDTH'(1);
            end
            advance_c = 1'b1;
          end else if (ptr_q != '0) begin
            ptr_d     = ptr_q - ADDR_WIDTH'(1);
            advance_c = 1'b1;
          end else begin
            // Bottom turnaround: step 0 is not replayed, resume upward at 1.
            dir_d     = 1'b0;
            ptr_d     = (len_clamp_c > LEN_W'(1)) ? ADDR_WIDTH'(1) : '0;
            restart_c = 1'b1;
          end
`else
          if (ptr_q == last_ptr_c) begin
            ptr_d     = '0;
            restart_c = 1'b1;
          end else begin
            ptr_d     = ptr_q + ADDR_WIDTH'(1);
            advance_c = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sequence restart: length is re-sampled here only; zero length parks in IDLE.
    if (restart_c) begin
      len_d = len_clamp_c;
      if (len_clamp_c == '0) begin
        state_d   = S_IDLE;
        led_d     = '0;
        playing_d = 1'b0;
      end else begin
        wrap_d    = 1'b1;
        advance_c = 1'b1;
      end
    end

    if (advance_c) begin
      state_d   = S_FETCH;
      r_en_d    = 1'b1;
      r_addr_d  = ptr_d;
      playing_d = 1'b1;
    end
  end

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      len_q     <= '0;
      r_en_q    <= 1'b0;
      r_addr_q  <= '0;
      led_q     <= '0;
      wrap_q    <= 1'b0;
      playing_q <= 1'b0;
`ifdef SEQUENCE_PLAYER_PINGPONG_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
      r_en_q    <= r_en_d;
      r_addr_q  <= r_addr_d;
      led_q     <= led_d;
      wrap_q    <= wrap_d;
      playing_q <= playing_d;
`ifdef SEQUENCE_PLAYER_PINGPONG_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign bus.r_en    = r_en_q;
  assign bus.r_addr  = r_addr_q;
  assign bus.led     = led_q;
  assign bus.wrap    = wrap_q;
  assign bus.playing = playing_q;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player: DUT A (HOLD_TICKS=1) and DUT B (HOLD_TICKS=4) share clock/reset.
module tb_sequence_player;
  localparam int unsigned MW = 2;
  localparam int unsigned AW = 3;
  localparam int unsigned NS = 8;
  localparam int unsigned FETCH_BUDGET = 20;

  logic div_clk = 1'b0;
  logic rst     = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [MW-1:0] mem [0:NS-1] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

  sequence_player_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus_a ();
  sequence_player_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus_b ();

  sequence_player #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .NUM_STEPS(NS), .HOLD_TICKS(1)) dut_a (
    .div_clk(div_clk), .rst(rst), .bus(bus_a)
  );
  sequence_player #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .NUM_STEPS(NS), .HOLD_TICKS(4)) dut_b (
    .div_clk(div_clk), .rst(rst), .bus(bus_b)
  );

  always #5 div_clk = ~div_clk;

  // Synchronous pattern memory: data valid the edge after r_en.
  always @(posedge div_clk or posedge rst) begin
    if (rst) bus_a.r_data <= '0;
    else if (bus_a.r_en) bus_a.r_data <= mem[bus_a.r_addr];
  end
  always @(posedge div_clk or posedge rst) begin
    if (rst) bus_b.r_data <= '0;
    else if (bus_b.r_en) bus_b.r_data <= mem[bus_b.r_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_fetch(input bit use_b, output logic [AW-1:0] addr,
                            output logic wrap_seen, output int cycles, output bit ok);
    ok = 1'b0; addr = '0; wrap_seen = 1'b0; cycles = 0;
    for (int i = 0; i < int'(FETCH_BUDGET); i++) begin
      tick();
      cycles = i + 1;
      if (use_b ? bus_b.r_en : bus_a.r_en) begin
        addr      = use_b ? bus_b.r_addr : bus_a.r_addr;
        wrap_seen = use_b ? bus_b.wrap : bus_a.wrap;
        ok        = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] got;
    tick();
    got = {bus_a.r_en, bus_a.r_addr, bus_a.led, bus_a.wrap};
    n_tests++;
    if (got !== 7'd0 || bus_a.playing !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b playing %b expected all zero", got, bus_a.playing);
    end
    got = {bus_b.r_en, bus_b.r_addr, bus_b.led, bus_b.wrap};
    n_tests++;
    if (got !== 7'd0 || bus_b.playing !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b playing %b expected all zero", got, bus_b.playing);
    end
  endtask

  task automatic test_sequence();
    logic [4:0] got, exp;
    logic e_ren, e_wrap;
    logic [MW-1:0] e_led;
    int phase, step;
    bus_a.seq_len = 4'd8;
    bus_a.run     = 1'b1;
    pulse_reset();
    for (int n = 1; n <= 52; n++) begin
      tick();
      phase  = (n - 1) % 3;
      step   = (n - 1) / 3;
      e_ren  = (phase == 0);
      e_wrap = (phase == 0) && (step != 0) && (step % 8 == 0);
      e_led  = (n < 3) ? '0 : mem[((n - 3) / 3) % 8];
      exp = {e_ren, e_led, e_wrap, 1'b1};
      got = {bus_a.r_en, bus_a.led, bus_a.wrap, bus_a.playing};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL seq_cycle%0d {r_en,led,wrap,playing}: got %b expected %b", n, got, exp);
      end
      if (phase == 0) begin
        n_tests++;
        if (bus_a.r_addr !== AW'(step % 8)) begin
          n_fail++;
          $display("FAIL seq_addr_cycle%0d: got %0d expected %0d", n, bus_a.r_addr, step % 8);
        end
      end
    end
  endtask

  task automatic test_short_len();
    logic [AW-1:0] exp_addr [0:11] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic          exp_wrap [0:11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [AW-1:0] addr;
    logic wr;
    int cyc;
    bit ok;
    bus_a.seq_len = 4'd3;
    bus_a.run     = 1'b1;
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      wait_fetch(1'b0, addr, wr, cyc, ok);
      n_tests++;
      if (!ok || addr !== exp_addr[i] || wr !== exp_wrap[i]) begin
        n_fail++;
        $display("FAIL len_fetch%0d: got ok=%0d addr=%0d wrap=%b expected addr=%0d wrap=%b",
                 i, ok, addr, wr, exp_addr[i], exp_wrap[i]);
      end
      if (i == 4) bus_a.seq_len = 4'd5;
      tick();
      tick();
      n_tests++;
      if (bus_a.led !== mem[exp_addr[i]]) begin
        n_fail++;
        $display("FAIL len_led%0d: got %0d expected %0d", i, bus_a.led, mem[exp_addr[i]]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [AW-1:0] addr;
    logic wr;
    int cyc;
    bit ok;
    bus_a.seq_len = 4'd12;
    bus_a.run     = 1'b1;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      wait_fetch(1'b0, addr, wr, cyc, ok);
      n_tests++;
      if (!ok || addr !== AW'(i % 8) || wr !== (i == 8)) begin
        n_fail++;
        $display("FAIL clamp_fetch%0d: got ok=%0d addr=%0d wrap=%b expected addr=%0d wrap=%b",
                 i, ok, addr, wr, i % 8, (i == 8));
      end
    end
  endtask

  task automatic test_run_stop();
    logic [AW-1:0] addr;
    logic [3:0] got;
    logic wr;
    int cyc;
    bit ok;
    bus_a.run     = 1'b0;
    bus_b.seq_len = 4'd8;
    bus_b.run     = 1'b1;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      wait_fetch(1'b1, addr, wr, cyc, ok);
      n_tests++;
      if (!ok || addr !== AW'(i) || (i > 0 && cyc != 6)) begin
        n_fail++;
        $display("FAIL stop_fetch%0d: got ok=%0d addr=%0d period=%0d expected addr=%0d period=6",
                 i, ok, addr, cyc, i);
      end
    end
    tick();
    tick();
    n_tests++;
    if (bus_b.led !== 2'd3) begin
      n_fail++;
      $display("FAIL stop_first_show_led: got %0d expected 3", bus_b.led);
    end
    bus_b.run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = {bus_b.r_en, bus_b.led, bus_b.playing};
      n_tests++;
      if (got !== 4'b0111) begin
        n_fail++;
        $display("FAIL stop_hold%0d {r_en,led,playing}: got %b expected 0111", k, got);
      end
    end
    tick();
    got = {bus_b.r_en, bus_b.led, bus_b.playing};
    n_tests++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL stop_idle {r_en,led,playing}: got %b expected 0000", got);
    end
    tick();
    tick();
    tick();
    n_tests++;
    if (bus_b.playing !== 1'b0 || bus_b.r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_stays_idle: got playing=%b r_en=%b expected 0 0", bus_b.playing, bus_b.r_en);
    end
    bus_b.run = 1'b1;
    tick();
    n_tests++;
    if (bus_b.r_en !== 1'b1 || bus_b.r_addr !== 3'd0 || bus_b.playing !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_fetch: got r_en=%b addr=%0d playing=%b expected 1 0 1",
               bus_b.r_en, bus_b.r_addr, bus_b.playing);
    end
    tick();
    tick();
    n_tests++;
    if (bus_b.led !== 2'd1) begin
      n_fail++;
      $display("FAIL restart_led: got %0d expected 1", bus_b.led);
    end
    bus_b.run = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] addr;
    logic [7:0] got;
    logic wr;
    int cyc;
    bit ok;
    bit found;
    found = 1'b0;
    bus_a.seq_len = 4'd8;
    bus_a.run     = 1'b1;
    pulse_reset();
    for (int i = 0; i < 8 && !found; i++) begin
      wait_fetch(1'b0, addr, wr, cyc, ok);
      if (ok && addr == 3'd5) found = 1'b1;
    end
    n_tests++;
    if (!found || bus_a.led !== 2'd3 || bus_a.playing !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: got found=%0d led=%0d playing=%b expected 1 3 1",
               found, bus_a.led, bus_a.playing);
    end
    #2;
    rst = 1'b1;
    #1;
    got = {bus_a.r_en, bus_a.r_addr, bus_a.led, bus_a.wrap, bus_a.playing};
    n_tests++;
    if (got !== 8'd0) begin
      n_fail++;
      $display("FAIL arst_immediate: got %b expected 00000000", got);
    end
    tick();
    got = {bus_a.r_en, bus_a.r_addr, bus_a.led, bus_a.wrap, bus_a.playing};
    n_tests++;
    if (got !== 8'd0) begin
      n_fail++;
      $display("FAIL arst_held: got %b expected 00000000", got);
    end
    rst = 1'b0;
    tick();
    got = {bus_a.r_en, bus_a.r_addr, bus_a.led, bus_a.wrap, bus_a.playing};
    n_tests++;
    if (got !== 8'b10000001) begin
      n_fail++;
      $display("FAIL arst_release_fetch {r_en,addr,led,wrap,playing}: got %b expected 10000001", got);
    end
    tick();
    tick();
    n_tests++;
    if (bus_a.led !== 2'd1) begin
      n_fail++;
      $display("FAIL arst_release_led: got %0d expected 1", bus_a.led);
    end
  endtask

`ifdef SEQUENCE_PLAYER_PINGPONG_EN
  task automatic test_pingpong();
    logic [AW-1:0] exp_addr [0:8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    logic [AW-1:0] addr;
    logic wr;
    int cyc;
    bit ok;
    bus_a.seq_len = 4'd4;
    bus_a.run     = 1'b1;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      wait_fetch(1'b0, addr, wr, cyc, ok);
      n_tests++;
      if (!ok || addr !== exp_addr[i] || wr !== (i == 7)) begin
        n_fail++;
        $display("FAIL pingpong_fetch%0d: got ok=%0d addr=%0d wrap=%b expected addr=%0d wrap=%b",
                 i, ok, addr, wr, exp_addr[i], (i == 7));
      end
    end
  endtask
`endif

  initial begin
    bus_a.run = 1'b0; bus_a.seq_len = '0;
    bus_b.run = 1'b0; bus_b.seq_len = '0;
    test_reset();
    test_sequence();
    test_short_len();
    test_clamp();
    test_run_stop();
    test_async_reset();
`ifdef SEQUENCE_PLAYER_PINGPONG_EN
    test_pingpong();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
